// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 2-flop synchronizer and tick-rate majority filter; optional idle detect via UART_RX_IDLE_DETECT_EN.
// Latency: byte strobe one clk after the mid-stop-bit baudtick (~80 ticks after the start edge).
// Backpressure: none; rx_data_ready is a one-clk strobe and rx_data holds until the next good byte.
module uart_receiver #(
    parameter int OVERSAMPLE = 8,
    parameter int DATABITS   = 8,
    parameter int IDLEBITS   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baudtick,
    input  logic                rxd,
    output logic [DATABITS-1:0] rx_data,
    output logic                rx_data_ready,
    output logic                rx_framing_error,
    output logic                rx_busy,
    output logic                rx_idle,
    output logic                rx_endofpacket
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATABITS + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    generate
        if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 || IDLEBITS < 1 || DATABITS < 1) begin : g_bad_param
            $error("uart_receiver: illegal parameter set");
        end
    endgenerate

    logic                sync1, sync2;
    logic [1:0]          filt_cnt, filt_nxt;
    logic                rx_bit;
    state_t              state, state_nxt;
    logic [TW-1:0]       tickcnt, tick_nxt;
    logic [BW-1:0]       bitcnt, bit_nxt;
    logic [DATABITS-1:0] shift, shift_nxt;
    logic                good, ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
        end
    end

    always_comb begin
        filt_nxt = filt_cnt;
        if (sync2 && filt_cnt != 2'd3)
            filt_nxt = filt_cnt + 2'd1;
        else if (!sync2 && filt_cnt != 2'd0)
            filt_nxt = filt_cnt - 2'd1;
    end

    // rx_bit only flips at the saturation points, so short glitches are absorbed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= 2'd0;
            rx_bit   <= 1'b1;
        end else if (baudtick) begin
            filt_cnt <= filt_nxt;
            if (filt_nxt == 2'd3)
                rx_bit <= 1'b1;
            else if (filt_nxt == 2'd0)
                rx_bit <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tickcnt;
        bit_nxt   = bitcnt;
        shift_nxt = shift;
        good      = 1'b0;
        ferr      = 1'b0;
        if (baudtick) begin
            case (state)
                IDLE: begin
                    if (!rx_bit) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    if (tickcnt == TW'(OVERSAMPLE / 2 - 1)) begin
                        tick_nxt = '0;
                        bit_nxt  = '0;
                        state_nxt = rx_bit ? IDLE : DATA;
                    end else begin
                        tick_nxt = tickcnt + TW'(1);
                    end
                end
                DATA: begin
                    tick_nxt = tickcnt + TW'(1);
                    if (tickcnt == TW'(OVERSAMPLE - 1)) begin
                        shift_nxt = {rx_bit, shift[DATABITS-1:1]};
                        bit_nxt   = bitcnt + BW'(1);
                        if (bitcnt == BW'(DATABITS - 1))
                            state_nxt = STOP;
                    end
                end
                STOP: begin
                    tick_nxt = tickcnt + TW'(1);
                    // leave at mid stop bit so an immediately following start edge is caught
                    if (tickcnt == TW'(OVERSAMPLE - 1)) begin
                        state_nxt = IDLE;
                        good      = rx_bit;
                        ferr      = !rx_bit;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            tickcnt          <= '0;
            bitcnt           <= '0;
            shift            <= '0;
            rx_data          <= '0;
            rx_data_ready    <= 1'b0;
            rx_framing_error <= 1'b0;
        end else begin
            state            <= state_nxt;
            tickcnt          <= tick_nxt;
            bitcnt           <= bit_nxt;
            shift            <= shift_nxt;
            rx_data_ready    <= good;
            rx_framing_error <= ferr;
            if (good)
                rx_data <= shift;
        end
    end

    assign rx_busy = (state != IDLE);

`ifdef UART_RX_IDLE_DETECT_EN
    localparam int IDLEMAX = IDLEBITS * OVERSAMPLE;
    localparam int IW      = $clog2(IDLEMAX + 1);

    logic [IW-1:0] idlecnt, idle_nxt;
    logic          got_byte;
    logic          idle_rise;

    always_comb begin
        idle_nxt = idlecnt;
        if (baudtick && state == IDLE) begin
            if (!rx_bit)
                idle_nxt = '0;
            else if (idlecnt != IW'(IDLEMAX))
                idle_nxt = idlecnt + IW'(1);
        end
    end

    assign idle_rise = (idle_nxt == IW'(IDLEMAX)) && !rx_idle;

    // end-of-packet only fires if a good byte landed since the last idle period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idlecnt        <= '0;
            rx_idle        <= 1'b0;
            rx_endofpacket <= 1'b0;
            got_byte       <= 1'b0;
        end else begin
            idlecnt        <= idle_nxt;
            rx_idle        <= (idle_nxt == IW'(IDLEMAX));
            rx_endofpacket <= idle_rise && got_byte;
            if (idle_rise)
                got_byte <= 1'b0;
            else if (good)
                got_byte <= 1'b1;
        end
    end
`else
    assign rx_idle        = 1'b0;
    assign rx_endofpacket = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames plus randomized byte streams checked against a queue model.
module tb_uart_receiver;

    localparam int OS     = 8;
    localparam int TDIV   = 4;
    localparam int BITCLK = OS * TDIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       baudtick;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_framing_error;
    logic       rx_busy;
    logic       rx_idle;
    logic       rx_endofpacket;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [7:0] got_q[$];
    int         rdy_cyc_q[$];
    bit         busy_fell_q[$];
    int ferr_cnt = 0, wide_cnt = 0, eop_cnt = 0, eop_cyc = 0;
    int idle_rise_cnt = 0, idle_rise_cyc = 0, idle_seen = 0, busy_seen = 0;
    int start_cyc = 0;
    logic [7:0] last_good;

    uart_receiver #(.OVERSAMPLE(OS), .DATABITS(8), .IDLEBITS(10)) dut (
        .clk              (clk),
        .rst              (rst),
        .baudtick         (baudtick),
        .rxd              (rxd),
        .rx_data          (rx_data),
        .rx_data_ready    (rx_data_ready),
        .rx_framing_error (rx_framing_error),
        .rx_busy          (rx_busy),
        .rx_idle          (rx_idle),
        .rx_endofpacket   (rx_endofpacket)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int div;
        div = 0;
        baudtick = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % TDIV;
            baudtick = (div == 0);
        end
    end

    initial begin
        bit prev_rdy, prev_ferr, prev_busy, prev_idle;
        prev_rdy = 0; prev_ferr = 0; prev_busy = 0; prev_idle = 0;
        forever begin
            @(negedge clk);
            if (rx_data_ready === 1'b1) begin
                got_q.push_back(rx_data);
                rdy_cyc_q.push_back(cyc);
                busy_fell_q.push_back(prev_busy && !rx_busy);
                if (prev_rdy) wide_cnt++;
            end
            if (rx_framing_error === 1'b1) begin
                ferr_cnt++;
                if (prev_ferr) wide_cnt++;
            end
            if (rx_endofpacket === 1'b1) begin
                eop_cnt++;
                eop_cyc = cyc;
            end
            if (rx_idle === 1'b1 && !prev_idle) begin
                idle_rise_cnt++;
                idle_rise_cyc = cyc;
            end
            if (rx_idle === 1'b1) idle_seen++;
            if (rx_busy === 1'b1) busy_seen++;
            prev_rdy  = (rx_data_ready === 1'b1);
            prev_ferr = (rx_framing_error === 1'b1);
            prev_busy = (rx_busy === 1'b1);
            prev_idle = (rx_idle === 1'b1);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        got_q.delete();
        rdy_cyc_q.delete();
        busy_fell_q.delete();
        ferr_cnt  = 0;
        busy_seen = 0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb);
        start_cyc = cyc;
        rxd = 1'b0;
        wait_clk(BITCLK);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clk(BITCLK);
        end
        rxd = stopb;
        wait_clk(BITCLK);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        wait_clk(5);
        checks++;
        if ({rx_data, rx_data_ready, rx_framing_error, rx_busy, rx_idle, rx_endofpacket} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {rx_data, rx_data_ready, rx_framing_error, rx_busy, rx_idle, rx_endofpacket});
        end
        rst = 1'b0;
        wait_clk(400);
`ifdef UART_RX_IDLE_DETECT_EN
        checks++;
        if (rx_idle !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle_rise: got %b expected 1", rx_idle);
        end
        checks++;
        if (eop_cnt != 0) begin
            fails++;
            $display("FAIL reset_no_eop: got %0d expected 0", eop_cnt);
        end
`else
        checks++;
        if (rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_busy: got %b expected 0", rx_busy);
        end
`endif
    endtask

    task automatic test_basic();
        int lat;
        clear_obs();
        send_frame(8'hA5, 1'b1);
        wait_clk(2 * BITCLK);
        last_good = 8'hA5;
        checks++;
        if (got_q.size() != 1) begin
            fails++;
            $display("FAIL basic_count: got %0d expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 8'hA5) begin
                fails++;
                $display("FAIL basic_data: got %h expected a5", got_q[0]);
            end
            lat = rdy_cyc_q[0] - start_cyc;
            checks++;
            if (lat < 72 * TDIV || lat > 84 * TDIV) begin
                fails++;
                $display("FAIL basic_latency: got %0d clk expected %0d..%0d", lat, 72 * TDIV, 84 * TDIV);
            end
            checks++;
            if (busy_fell_q[0] !== 1'b1) begin
                fails++;
                $display("FAIL basic_busy_fall: got %b expected 1", busy_fell_q[0]);
            end
        end
        checks++;
        if (ferr_cnt != 0 || rx_data !== 8'hA5) begin
            fails++;
            $display("FAIL basic_hold: got ferr %0d data %h expected 0 / a5", ferr_cnt, rx_data);
        end
    endtask

    task automatic test_glitch();
        int widths[2];
        widths[0] = 1;
        widths[1] = 3;
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            rxd = 1'b0;
            wait_clk(widths[k] * TDIV);
            rxd = 1'b1;
            wait_clk(200);
            checks++;
            if (got_q.size() != 0 || ferr_cnt != 0 || rx_busy !== 1'b0 || rx_data !== last_good) begin
                fails++;
                $display("FAIL glitch_%0dtick: got rdy %0d ferr %0d busy %b data %h expected 0 0 0 %h",
                         widths[k], got_q.size(), ferr_cnt, rx_busy, rx_data, last_good);
            end
            checks++;
            if ((busy_seen > 0) != (widths[k] == 3)) begin
                fails++;
                $display("FAIL glitch_%0dtick_start: got busy cycles %0d expected start only for 3 ticks",
                         widths[k], busy_seen);
            end
        end
    endtask

    task automatic test_framing();
        clear_obs();
        send_frame(8'h3C, 1'b0);
        wait_clk(2 * BITCLK);
        checks++;
        if (ferr_cnt != 1 || got_q.size() != 0 || rx_data !== last_good) begin
            fails++;
            $display("FAIL framing_err: got ferr %0d rdy %0d data %h expected 1 0 %h",
                     ferr_cnt, got_q.size(), rx_data, last_good);
        end
        clear_obs();
        send_frame(8'h81, 1'b1);
        wait_clk(2 * BITCLK);
        last_good = 8'h81;
        checks++;
        if (got_q.size() != 1 || rx_data !== 8'h81 || ferr_cnt != 0) begin
            fails++;
            $display("FAIL framing_recover: got rdy %0d data %h ferr %0d expected 1 81 0",
                     got_q.size(), rx_data, ferr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[3];
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
        clear_obs();
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
        wait_clk(2 * BITCLK);
        last_good = 8'h55;
        checks++;
        if (got_q.size() != 3) begin
            fails++;
            $display("FAIL b2b_count: got %0d expected 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL b2b_data%0d: got %h expected %h", i, got_q[i], exp[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (rdy_cyc_q[i] - rdy_cyc_q[i-1] != 10 * BITCLK) begin
                    fails++;
                    $display("FAIL b2b_spacing%0d: got %0d expected %0d", i,
                             rdy_cyc_q[i] - rdy_cyc_q[i-1], 10 * BITCLK);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h96;
        clear_obs();
        rxd = 1'b0;
        wait_clk(BITCLK);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            wait_clk(BITCLK);
        end
        rxd = d[4];
        wait_clk(BITCLK / 2);
        rst = 1'b1;
        wait_clk(3);
        checks++;
        if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin
            fails++;
            $display("FAIL midreset_abort: got busy %b data %h expected 0 00", rx_busy, rx_data);
        end
        rst = 1'b0;
        rxd = 1'b1;
        wait_clk(4 * BITCLK);
        send_frame(8'h69, 1'b1);
        wait_clk(2 * BITCLK);
        last_good = 8'h69;
        checks++;
        if (got_q.size() != 1 || rx_data !== 8'h69 || ferr_cnt != 0) begin
            fails++;
            $display("FAIL midreset_next: got rdy %0d data %h ferr %0d expected 1 69 0",
                     got_q.size(), rx_data, ferr_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int   exp_ferr;
        bit   prev_bad, bad;
        logic [7:0] d;
        int   gap;
        exp_ferr = 0;
        prev_bad = 0;
        clear_obs();
        for (int i = 0; i < 16; i++) begin
            d    = 8'($urandom_range(0, 255));
            bad  = ($urandom_range(0, 4) == 0);
            gap  = prev_bad ? 2 : int'($urandom_range(0, 2));
            rxd  = 1'b1;
            wait_clk(gap * BITCLK);
            send_frame(d, !bad);
            if (bad) exp_ferr++;
            else begin
                exp_q.push_back(d);
                last_good = d;
            end
            prev_bad = bad;
        end
        wait_clk(2 * BITCLK);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL rand_data%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (ferr_cnt != exp_ferr || rx_data !== last_good) begin
            fails++;
            $display("FAIL rand_ferr_hold: got ferr %0d data %h expected %0d %h",
                     ferr_cnt, rx_data, exp_ferr, last_good);
        end
        checks++;
        if (wide_cnt != 0) begin
            fails++;
            $display("FAIL pulse_width: got %0d wide pulses expected 0", wide_cnt);
        end
    endtask

    task automatic test_idle();
        clear_obs();
        eop_cnt = 0;
        idle_rise_cnt = 0;
        idle_seen = 0;
        send_frame(8'h12, 1'b1);
        wait_clk(12 * BITCLK);
        checks++;
        if (got_q.size() != 1 || rx_data !== 8'h12) begin
            fails++;
            $display("FAIL idle_byte: got rdy %0d data %h expected 1 12", got_q.size(), rx_data);
        end
`ifdef UART_RX_IDLE_DETECT_EN
        checks++;
        if (idle_rise_cnt != 1 || got_q.size() == 0 || idle_rise_cyc - rdy_cyc_q[0] != 80 * TDIV) begin
            fails++;
            $display("FAIL idle_rise: got rises %0d at +%0d clk expected 1 at +%0d",
                     idle_rise_cnt, idle_rise_cyc - (got_q.size() > 0 ? rdy_cyc_q[0] : 0), 80 * TDIV);
        end
        checks++;
        if (eop_cnt != 1 || eop_cyc != idle_rise_cyc) begin
            fails++;
            $display("FAIL idle_eop: got %0d pulses at %0d expected 1 at %0d", eop_cnt, eop_cyc, idle_rise_cyc);
        end
        wait_clk(20 * BITCLK);
        checks++;
        if (eop_cnt != 1 || rx_idle !== 1'b1) begin
            fails++;
            $display("FAIL idle_hold: got eop %0d idle %b expected 1 1", eop_cnt, rx_idle);
        end
`else
        checks++;
        if (idle_seen != 0 || eop_cnt != 0) begin
            fails++;
            $display("FAIL idle_disabled: got idle cycles %0d eop %0d expected 0 0", idle_seen, eop_cnt);
        end
`endif
    endtask

    initial begin
        last_good = 8'h00;
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
